frame_sched: RTL

FRAME_SCHED -- requirements
Module: frame_sched

---
 rtl/frame_sched_pkg.sv | 16 +
 rtl/frame_sched_rr_pick.sv | 32 +++
 rtl/frame_sched.sv | 93 +++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
// Shared constants and state encodings for the frame scheduler.
// Sizes are fixed for this release; the counter is wide enough to hold WIDTH.
package frame_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int CNTW      = $clog2(WIDTH_DEF) + 1;
  localparam int IDW       = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/frame_sched_rr_pick.sv
// Combinational round-robin picker: search begins one past the last winner.
// Zero latency, no state; the caller decides when the result is used.
module rr_pick
  import frame_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] win_oh,
  output logic [IDW-1:0]  win_idx,
  output logic            any
);

  logic [IDW-1:0] idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last) + i) % NREQ);
      if (!any && req[idx]) begin
        any          = 1'b1;
        win_oh[idx]  = 1'b1;
        win_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/frame_sched.sv
// Round-robin frame scheduler: grants one requester, serialises its word MSB first.
// Frame takes WIDTH shift cycles plus one DONE cycle; req is ignored while busy.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  dout,
  output logic                  dout_vld,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] sreg;
  logic [CNTW-1:0]  cnt;
  logic [NREQ-1:0]  gnt_q;

  logic [NREQ-1:0]  pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .last    (last),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The unused fourth encoding falls through to IDLE.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = pick_any ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_nxt = (cnt == CNTW'(WIDTH - 1)) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= IDW'(NREQ - 1);
      win   <= '0;
      sreg  <= '0;
      cnt   <= '0;
      gnt_q <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_q <= pick_oh;
            win   <= pick_idx;
            sreg  <= wdata[int'(pick_idx)*WIDTH +: WIDTH];
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CNTW'(1);
        end
        ST_DONE: last <= win;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt      = gnt_q;
    busy     = (state != ST_IDLE);
    dout_vld = (state == ST_SHIFT);
    dout     = dout_vld & sreg[WIDTH-1];
    done     = (state == ST_DONE);
    done_id  = done ? win : '0;
  end

endmodule
